shift_unit_iter: RTL

//  Parametrised multi-cycle shifter for the datapath: SLL/SRL/SRA (opt. ROTR) by a runtime amount.

---
 rtl/shift_unit_pkg.sv | 18 +
 rtl/shift_step.sv | 54 +++++
 rtl/shift_unit_iter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/shift_unit_pkg.sv
// Shared definitions for the iterative shifter.
//   - Op encodings for the shift request (SLL/SRL/SRA/ROTR).
//   - FSM state encoding used by shift_unit_iter.
// Optional feature macro: ROTATE_SHIFT_EN (see shift_unit_iter.sv).
package shift_unit_pkg;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of WIDTH bits by 0..STEP positions.
// Ports:
//   data   in   WIDTH  value to shift
//   amt    in   AMT_W  positions to shift this step (0..STEP)
//   op     in   2      OP_SLL / OP_SRL / OP_SRA / OP_ROTR
//   sign   in   1      fill bit for SRA (operand MSB captured at start)
//   result out  WIDTH  shifted value
// Macro ROTATE_SHIFT_EN: when defined OP_ROTR rotates right, otherwise
// OP_ROTR passes data through unchanged.
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] result
);

  // One candidate per possible step amount; amt selects among them so each
  // candidate is a fixed-distance shift (pure wiring).
  logic [WIDTH-1:0] cand [STEP+1];

  for (genvar gi = 0; gi <= STEP; gi++) begin : g_amt
    if (gi == 0) begin : g_zero
      assign cand[gi] = data;
    end else begin : g_nz
      logic [WIDTH-1:0] rot;
`ifdef ROTATE_SHIFT_EN
      assign rot = {data[gi-1:0], data[WIDTH-1:gi]};
`else
      assign rot = data;
`endif
      assign cand[gi] = (op == OP_SLL) ? (data << gi) :
                        (op == OP_SRL) ? (data >> gi) :
                        (op == OP_SRA) ? {{gi{sign}}, data[WIDTH-1:gi]} :
                        rot;
    end
  end

  always_comb begin
    result = data;
    for (int k = 1; k <= STEP; k++) begin
      if (amt == AMT_W'(k)) begin
        result = cand[k];
      end
    end
  end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle shifter: SLL/SRL/SRA (and optionally ROTR) by a runtime
// amount, at most STEP bits per clock, with a Start/Busy/Done handshake.
// The result is held on ShiftOut until the next accepted Start completes.
// Ports:
//   Clk      in   1        clock, rising edge
//   Reset    in   1        asynchronous, active-high
//   Start    in   1        request, sampled only while not busy
//   Op       in   2        00 SLL, 01 SRL, 10 SRA, 11 ROTR / pass-through
//   ShAmt    in   SHAMT_W  shift amount 0..WIDTH-1
//   ShiftIn  in   WIDTH    operand
//   Busy     out  1        high while shifting
//   Done     out  1        one-cycle pulse, ShiftOut valid
//   ShiftOut out  WIDTH    result
// Macro ROTATE_SHIFT_EN: defined -> Op=11 rotates right with normal
// latency; undefined -> Op=11 returns ShiftIn with zero shift cycles.
module shift_unit_iter
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [1:0]         Op,
  input  logic [SHAMT_W-1:0] ShAmt,
  input  logic [WIDTH-1:0]   ShiftIn,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   ShiftOut
);

  localparam int AMT_W = $clog2(STEP + 1);

  state_e             state_reg;
  logic [SHAMT_W-1:0] rem_reg;
  logic [WIDTH-1:0]   work_reg;
  logic [1:0]         op_reg;
  logic               sign_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   out_reg;

  logic [AMT_W-1:0]   step_amt;
  logic [SHAMT_W-1:0] rem_after;
  logic [SHAMT_W-1:0] start_rem;
  logic [WIDTH-1:0]   step_result;

  // Final step of a run may be shorter than STEP.
  assign step_amt  = (rem_reg >= SHAMT_W'(STEP)) ? AMT_W'(STEP) : AMT_W'(rem_reg);
  assign rem_after = rem_reg - SHAMT_W'(step_amt);

`ifdef ROTATE_SHIFT_EN
  assign start_rem = ShAmt;
`else
  // Without rotation Op=11 is a pass-through: no shift cycles at all.
  assign start_rem = (Op == OP_ROTR) ? '0 : ShAmt;
`endif

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data   (work_reg),
    .amt    (step_amt),
    .op     (op_reg),
    .sign   (sign_reg),
    .result (step_result)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      rem_reg   <= '0;
      work_reg  <= '0;
      op_reg    <= OP_SLL;
      sign_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      out_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          done_reg <= 1'b0;
          if (Start) begin
            work_reg <= ShiftIn;
            op_reg   <= Op;
            sign_reg <= ShiftIn[WIDTH-1];
            rem_reg  <= start_rem;
            if (start_rem == '0) begin
              // Zero-length request completes on the accepting edge.
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              out_reg   <= ShiftIn;
            end else begin
              state_reg <= ST_SHIFT;
              busy_reg  <= 1'b1;
            end
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          work_reg <= step_result;
          rem_reg  <= rem_after;
          if (rem_after == '0) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            out_reg   <= step_result;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy     = busy_reg;
  assign Done     = done_reg;
  assign ShiftOut = out_reg;

endmodule
